// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants: opcodes, immediate-format codes, stage states.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_SB   = 3'd3;
  localparam logic [2:0] IMM_UJ   = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;

  // EMPTY: nothing held; FULL: output register valid; SKID: output and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/immediategen.sv
// Immediate generator: produces every RV32 immediate format in parallel from one
// instruction word; the caller picks the one that matches the opcode.
module immediategen (
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_sb,
  output logic [31:0] o_imm_uj,
  output logic [31:0] o_imm_u
);

  // All formats sign-extend from instr[31]; branch/jump offsets are halfword aligned.
  always_comb begin
    o_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    o_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    o_imm_sb = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                i_instr[11:8], 1'b0};
    o_imm_uj = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                i_instr[30:21], 1'b0};
    o_imm_u  = {i_instr[31:12], 12'b0};
  end

endmodule

// File: rtl/id_imm_stage.sv
// Decode-stage immediate sequencer: classifies the opcode, selects the matching
// immediate and registers it toward EX behind a two-entry output/skid buffer.
// Handshake: a transfer happens on a rising edge where valid && ready; a producer
// holds valid and data stable until that edge, and ready never depends
// combinationally on the same-side valid. in_ready is a pure register output.
module id_imm_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal,
  output logic [1:0]      dbg_state
);

  logic [31:0]     w_imm_i, w_imm_s, w_imm_sb, w_imm_uj, w_imm_u;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_type;
  logic            w_illegal;

  stage_state_t    r_state, w_state_nxt;
  logic            r_in_ready;
  logic            w_in_xfer, w_out_xfer;
  logic            w_load_in, w_load_skid, w_load_from_skid;

  logic [31:0]     r_out_instr, r_skid_instr;
  logic [PC_W-1:0] r_out_pc, r_skid_pc;
  logic [XLEN-1:0] r_out_imm, r_skid_imm;
  logic [2:0]      r_out_type, r_skid_type;
  logic            r_out_illegal, r_skid_illegal;

  immediategen u_immgen (
    .i_instr  (in_instr),
    .o_imm_i  (w_imm_i),
    .o_imm_s  (w_imm_s),
    .o_imm_sb (w_imm_sb),
    .o_imm_uj (w_imm_uj),
    .o_imm_u  (w_imm_u)
  );

  // Opcode classification and immediate selection for the incoming instruction.
  always_comb begin
    w_type    = IMM_NONE;
    w_imm     = '0;
    w_illegal = 1'b0;
    case (in_instr[6:0])
      OPC_LUI, OPC_AUIPC:           begin w_type = IMM_U;  w_imm = w_imm_u;  end
      OPC_JAL:                      begin w_type = IMM_UJ; w_imm = w_imm_uj; end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin w_type = IMM_I;  w_imm = w_imm_i;  end
      OPC_STORE:                    begin w_type = IMM_S;  w_imm = w_imm_s;  end
      OPC_BRANCH:                   begin w_type = IMM_SB; w_imm = w_imm_sb; end
      OPC_OP:                       w_type = IMM_NONE;
      default:                      w_illegal = 1'b1;
    endcase
  end

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = (r_state != ST_EMPTY) && out_ready;

  // Next-state and register-load decisions; flush overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_in        = 1'b0;
    w_load_skid      = 1'b0;
    w_load_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_load_in   = 1'b1;
        end
        ST_FULL: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_in = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in_xfer) begin
            w_state_nxt = ST_SKID;
            w_load_skid = 1'b1;
          end
        end
        ST_SKID: if (w_out_xfer) begin
          w_state_nxt      = ST_FULL;
          w_load_from_skid = 1'b1;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State register; in_ready is precomputed so it has no path from out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
    end
  end

  // Output and skid data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_instr    <= '0;
      r_out_pc       <= '0;
      r_out_imm      <= '0;
      r_out_type     <= IMM_NONE;
      r_out_illegal  <= 1'b0;
      r_skid_instr   <= '0;
      r_skid_pc      <= '0;
      r_skid_imm     <= '0;
      r_skid_type    <= IMM_NONE;
      r_skid_illegal <= 1'b0;
    end else begin
      if (w_load_in) begin
        r_out_instr   <= in_instr;
        r_out_pc      <= in_pc;
        r_out_imm     <= w_imm;
        r_out_type    <= w_type;
        r_out_illegal <= w_illegal;
      end else if (w_load_from_skid) begin
        r_out_instr   <= r_skid_instr;
        r_out_pc      <= r_skid_pc;
        r_out_imm     <= r_skid_imm;
        r_out_type    <= r_skid_type;
        r_out_illegal <= r_skid_illegal;
      end
      if (w_load_skid) begin
        r_skid_instr   <= in_instr;
        r_skid_pc      <= in_pc;
        r_skid_imm     <= w_imm;
        r_skid_type    <= w_type;
        r_skid_illegal <= w_illegal;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state != ST_EMPTY);
  assign out_instr    = r_out_instr;
  assign out_pc       = r_out_pc;
  assign out_imm      = r_out_imm;
  assign out_imm_type = r_out_type;
  assign out_illegal  = r_out_illegal;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_id_imm_stage.sv
// Bench for id_imm_stage: directed scenarios plus random traffic, checked by a
// scoreboard fed from a reference decoder model.
module tb_id_imm_stage;

  localparam int EW = 100;  // instr + pc + imm + type + illegal

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic        out_illegal;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  id_imm_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_imm_type(out_imm_type),
    .out_illegal(out_illegal), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] ref_entry(input logic [31:0] ins, input logic [31:0] pc);
    int          s;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
    s   = int'(ins);
    imm = 32'd0;
    typ = 3'd0;
    ill = 1'b0;
    case (ins[6:0])
      7'h37, 7'h17: begin imm = ins & 32'hFFFF_F000; typ = 3'd5; end
      7'h6F: begin
        imm = 32'((s >>> 31) << 20) | (((ins >> 12) & 32'hFF) << 12)
            | (((ins >> 20) & 32'd1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
        typ = 3'd4;
      end
      7'h67, 7'h03, 7'h13: begin imm = 32'(s >>> 20); typ = 3'd1; end
      7'h23: begin imm = 32'((s >>> 25) << 5) | ((ins >> 7) & 32'd31); typ = 3'd2; end
      7'h63: begin
        imm = 32'((s >>> 31) << 12) | (((ins >> 7) & 32'd1) << 11)
            | (((ins >> 25) & 32'd63) << 5) | (((ins >> 8) & 32'd15) << 1);
        typ = 3'd3;
      end
      7'h33: begin imm = 32'd0; typ = 3'd0; end
      default: begin imm = 32'd0; typ = 3'd0; ill = 1'b1; end
    endcase
    return {ins, pc, imm, typ, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          stall_hold = 1'b0;
  logic [EW-1:0] held;

  always @(negedge clk) begin
    logic [EW-1:0] got, exp;
    if (!rst) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_type_ill", {28'd0, out_imm_type, out_illegal}, 32'd0);
      exp_q.delete();
      stall_hold = 1'b0;
    end else begin
      got = {out_instr, out_pc, out_imm, out_imm_type, out_illegal};
      chk("occ_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      chk("occ_in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      if (stall_hold) begin
        checks++;
        if (!out_valid || got !== held) begin
          errors++;
          $display("FAIL stall_hold actual=%h/%0b required=%h/1", got, out_valid, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected actual=%h required=none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL out_entry actual instr=%h pc=%h imm=%h type=%0d ill=%0b required instr=%h pc=%h imm=%h type=%0d ill=%0b",
                     got[99:68], got[67:36], got[35:4], got[3:1], got[0],
                     exp[99:68], exp[67:36], exp[35:4], exp[3:1], exp[0]);
          end
        end
      end
      stall_hold = out_valid && !out_ready && !flush;
      held = got;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(ref_entry(in_instr, in_pc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept instr=%h", ins);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] opc_tab [10];

  initial begin
    logic [31:0] r;
    logic        xfer;
    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33, 7'h7F};

    // Reset with a valid instruction presented.
    in_valid = 1'b1;
    in_instr = 32'hFFF0_0093;
    tick(3);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    tick(1);

    // addi x1,x0,-1
    send(32'hFFF0_0093, 32'h100);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_type", {29'd0, out_imm_type}, 32'd1);
    chk("addi_ill", {31'd0, out_illegal}, 32'd0);

    // Back-to-back stream
    send(32'h00C0_006F, 32'h104);
    chk("jal_imm", out_imm, 32'h0000_000C);
    chk("jal_type", {29'd0, out_imm_type}, 32'd4);
    send(32'hFE20_8EE3, 32'h108);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_type", {29'd0, out_imm_type}, 32'd3);
    send(32'h1234_5037, 32'h10C);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_type", {29'd0, out_imm_type}, 32'd5);
    tick(3);

    // Stall: sw then add while EX is stalled
    out_ready = 1'b0;
    send(32'h0020_A423, 32'h200);
    chk("sw_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h0020_81B3, 32'h204);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_imm", out_imm, 32'h0000_0008);
    chk("stall_type", {29'd0, out_imm_type}, 32'd2);
    tick(2);
    chk("stall_hold_imm", out_imm, 32'h0000_0008);
    out_ready = 1'b1;
    tick(1);
    chk("add_type", {29'd0, out_imm_type}, 32'd0);
    chk("add_imm", out_imm, 32'd0);
    chk("add_instr", out_instr, 32'h0020_81B3);
    tick(3);

    // Flush while in SKID with a new input presented
    out_ready = 1'b0;
    send(32'h0040_0093, 32'h300);
    send(32'h0080_0113, 32'h304);
    in_valid = 1'b1;
    in_instr = 32'h00C0_0193;
    in_pc    = 32'h308;
    flush    = 1'b1;
    tick(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick(3);

    // Illegal opcode, then a legal instruction
    send(32'h0000_007F, 32'h400);
    chk("illegal_flag", {31'd0, out_illegal}, 32'd1);
    chk("illegal_type", {29'd0, out_imm_type}, 32'd0);
    chk("illegal_imm", out_imm, 32'd0);
    send(32'h0010_0093, 32'h404);
    chk("legal_clears_ill", {31'd0, out_illegal}, 32'd0);
    tick(3);

    // Asynchronous reset in SKID
    out_ready = 1'b0;
    send(32'h0011_0113, 32'h500);
    send(32'h0021_0213, 32'h504);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_imm", out_imm, 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    tick(2);
    rst = 1'b1;
    out_ready = 1'b1;
    tick(1);
    send(32'h0050_0113, 32'h600);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_imm", out_imm, 32'd5);
    tick(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      xfer = in_valid && in_ready && !flush;
      @(posedge clk);
      #1;
      if (!in_valid || xfer) begin
        r = $urandom();
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = {r[31:7], opc_tab[$urandom_range(0, 9)]};
        in_pc    = $urandom();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(5);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
